// File: rtl/tf_pkg.sv
// Shared widths, metadata field positions, FSM encoding and word-count helper for the
// transmit scheduler.
package tf_pkg;

  localparam int unsigned MD_W    = 112;
  localparam int unsigned DATA_W  = 520;
  localparam int unsigned LEN_MSB = 106;
  localparam int unsigned LEN_LSB = 96;
  localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } state_e;

  // 64-byte data words needed for a byte length; 1..2047 maps to 1..32.
  function automatic logic [5:0] pkt_words(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W + 1)'(63);
    return sum[LEN_W:6];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, with wrap.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last_grant,
  output logic [PW-1:0] grant,
  output logic          any_req
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/tf_tx_sched.sv
// Round-robin scheduler feeding one source's metadata word and then all its data words
// into the shared transmit converter, honouring converter almost-full.
module tf_tx_sched
  import tf_pkg::*;
#(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned PW      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        src_md_empty,
  input  logic [N_PORTS*MD_W-1:0]   src_md,
  output logic [N_PORTS-1:0]        src_md_rd,
  input  logic [N_PORTS*DATA_W-1:0] src_data,
  output logic [N_PORTS-1:0]        src_data_rd,
  output logic [DATA_W-1:0]         tf_in,
  output logic                      tf_in_wr,
  output logic [MD_W-1:0]           tf_in_valid,
  output logic                      tf_in_valid_wr,
  input  logic                      tf_out_alf,
  output logic [PW-1:0]             cur_port,
  output logic [7:0]                pkt_cnt,
  output logic [7:0]                drop_cnt
);

  state_e            state_q, state_d;
  logic [PW-1:0]     last_grant_q;
  logic [5:0]        rem_q;
  logic [N_PORTS-1:0] md_req;
  logic [PW-1:0]     grant;
  logic              any_req;
  logic [MD_W-1:0]   md_sel;
  logic [DATA_W-1:0] data_sel;
  logic [LEN_W-1:0]  md_len;
  logic              md_pop, data_pop;

  assign md_req = ~src_md_empty;

  rr_pick #(
    .N  (N_PORTS),
    .PW (PW)
  ) u_rr_pick (
    .req        (md_req),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_req    (any_req)
  );

  // Pops are combinational so the head word is captured on the same edge that pops it.
  always_comb begin
    md_sel      = src_md[int'(grant)*MD_W +: MD_W];
    data_sel    = src_data[int'(cur_port)*DATA_W +: DATA_W];
    md_len      = md_sel[LEN_MSB:LEN_LSB];
    md_pop      = !rst && (state_q == StIdle) && !tf_out_alf && any_req;
    data_pop    = !rst && (state_q == StSend) && !tf_out_alf;
    src_md_rd   = md_pop ? (N_PORTS'(1) << grant) : '0;
    src_data_rd = data_pop ? (N_PORTS'(1) << cur_port) : '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (md_pop && (md_len != '0)) state_d = StSend;
      StSend: if (data_pop && (rem_q == 6'd1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      last_grant_q   <= PW'(N_PORTS - 1);
      rem_q          <= '0;
      tf_in          <= '0;
      tf_in_wr       <= 1'b0;
      tf_in_valid    <= '0;
      tf_in_valid_wr <= 1'b0;
      cur_port       <= '0;
      pkt_cnt        <= '0;
      drop_cnt       <= '0;
    end else begin
      state_q        <= state_d;
      tf_in_wr       <= 1'b0;
      tf_in_valid_wr <= 1'b0;
      if (md_pop) begin
        tf_in_valid <= md_sel;
        cur_port    <= grant;
        if (md_len != '0) begin
          tf_in_valid_wr <= 1'b1;
          rem_q          <= pkt_words(md_len);
        end else begin
          drop_cnt     <= drop_cnt + 8'd1;
          last_grant_q <= grant;
        end
      end
      if (data_pop) begin
        tf_in    <= data_sel;
        tf_in_wr <= 1'b1;
        rem_q    <= rem_q - 6'd1;
        if (rem_q == 6'd1) begin
          pkt_cnt      <= pkt_cnt + 8'd1;
          last_grant_q <= cur_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_tf_tx_sched.sv
// Self-checking bench: source FIFOs modelled as queues, expected behaviour derived from
// the packet-level scheduling rules and compared every cycle.
module tb_tf_tx_sched;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     src_md_empty;
  logic [N*112-1:0] src_md;
  logic [N-1:0]     src_md_rd;
  logic [N*520-1:0] src_data;
  logic [N-1:0]     src_data_rd;
  logic [519:0]     tf_in;
  logic             tf_in_wr;
  logic [111:0]     tf_in_valid;
  logic             tf_in_valid_wr;
  logic             tf_out_alf;
  logic [1:0]       cur_port;
  logic [7:0]       pkt_cnt;
  logic [7:0]       drop_cnt;

  tf_tx_sched #(
    .N_PORTS (N),
    .PW      (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .src_md_empty   (src_md_empty),
    .src_md         (src_md),
    .src_md_rd      (src_md_rd),
    .src_data       (src_data),
    .src_data_rd    (src_data_rd),
    .tf_in          (tf_in),
    .tf_in_wr       (tf_in_wr),
    .tf_in_valid    (tf_in_valid),
    .tf_in_valid_wr (tf_in_valid_wr),
    .tf_out_alf     (tf_out_alf),
    .cur_port       (cur_port),
    .pkt_cnt        (pkt_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  // Source FIFOs (popped by the DUT) and expected-packet queues (popped by the model).
  logic [111:0] src_md_q  [N][$];
  logic [519:0] src_dat_q [N][$];
  logic [111:0] exp_md_q  [N][$];
  logic [519:0] exp_dat_q [N][$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state and expected registered outputs.
  bit           m_send;
  int           m_port, m_last, m_rem;
  logic         e_valid_wr, e_wr;
  logic [111:0] e_valid;
  logic [519:0] e_in;
  logic [1:0]   e_cur;
  logic [7:0]   e_pkt, e_drop;
  logic [N-1:0] act_md_rd, act_data_rd;

  task automatic check(input string tag, input logic [519:0] got, input logic [519:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      src_md_empty[p]        = (src_md_q[p].size() == 0);
      src_md[p*112 +: 112]   = (src_md_q[p].size() != 0) ? src_md_q[p][0] : '0;
      src_data[p*520 +: 520] = (src_dat_q[p].size() != 0) ? src_dat_q[p][0] : '0;
    end
  endtask

  task automatic push(input int p, input int len);
    logic [111:0] md;
    logic [519:0] w;
    md = '0;
    for (int i = 0; i < 4; i++) md = {md[79:0], 32'($urandom)};
    md[106:96] = 11'(len);
    src_md_q[p].push_back(md);
    exp_md_q[p].push_back(md);
    for (int k = 0; k < (len + 63) / 64; k++) begin
      w = '0;
      for (int i = 0; i < 17; i++) w = {w[487:0], 32'($urandom)};
      src_dat_q[p].push_back(w);
      exp_dat_q[p].push_back(w);
    end
    drive_inputs();
  endtask

  task automatic model_step();
    logic [N-1:0] p_md, p_d;
    logic [111:0] md;
    int len, g;
    check("valid_wr", 520'(tf_in_valid_wr), 520'(e_valid_wr));
    check("tf_in_valid", 520'(tf_in_valid), 520'(e_valid));
    check("tf_in_wr", 520'(tf_in_wr), 520'(e_wr));
    check("tf_in", tf_in, e_in);
    check("cur_port", 520'(cur_port), 520'(e_cur));
    check("pkt_cnt", 520'(pkt_cnt), 520'(e_pkt));
    check("drop_cnt", 520'(drop_cnt), 520'(e_drop));
    check("strobe_excl", 520'(tf_in_wr & tf_in_valid_wr), 520'(0));
    act_md_rd   = src_md_rd;
    act_data_rd = src_data_rd;
    p_md = '0;
    p_d  = '0;
    g    = -1;
    if (!m_send && !tf_out_alf) begin
      for (int k = 1; k <= N; k++)
        if (g < 0 && exp_md_q[(m_last + k) % N].size() != 0) g = (m_last + k) % N;
    end
    if (rst) begin
      m_send = 0; m_last = N - 1; m_port = 0; m_rem = 0;
      e_valid_wr = 0; e_wr = 0; e_valid = '0; e_in = '0; e_cur = '0;
      e_pkt = '0; e_drop = '0;
      for (int p = 0; p < N; p++) begin
        src_md_q[p].delete(); src_dat_q[p].delete();
        exp_md_q[p].delete(); exp_dat_q[p].delete();
      end
      drive_inputs();
    end else if (g >= 0) begin
      p_md[g]    = 1'b1;
      md         = exp_md_q[g].pop_front();
      len        = int'(md[106:96]);
      e_valid    = md;
      e_cur      = 2'(g);
      e_wr       = 0;
      m_port     = g;
      if (len != 0) begin
        e_valid_wr = 1; m_rem = (len + 63) / 64; m_send = 1;
      end else begin
        e_valid_wr = 0; e_drop = e_drop + 8'd1; m_last = g;
      end
    end else if (m_send && !tf_out_alf) begin
      p_d[m_port] = 1'b1;
      if (exp_dat_q[m_port].size() != 0) e_in = exp_dat_q[m_port].pop_front();
      e_wr = 1; e_valid_wr = 0;
      m_rem--;
      if (m_rem == 0) begin
        e_pkt = e_pkt + 8'd1; m_last = m_port; m_send = 0;
      end
    end else begin
      e_wr = 0; e_valid_wr = 0;
    end
    check("md_rd", 520'(act_md_rd), 520'(p_md));
    check("data_rd", 520'(act_data_rd), 520'(p_d));
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (act_md_rd[p] && src_md_q[p].size() != 0) void'(src_md_q[p].pop_front());
      if (act_data_rd[p] && src_dat_q[p].size() != 0) void'(src_dat_q[p].pop_front());
    end
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = !m_send;
    for (int p = 0; p < N; p++) if (exp_md_q[p].size() != 0) idle = 0;
    return idle;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 520'(all_idle()), 520'(1));
    run(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    tf_out_alf = 1'b0;
    m_send = 0; m_last = N - 1; m_port = 0; m_rem = 0;
    e_valid_wr = 0; e_wr = 0; e_valid = '0; e_in = '0; e_cur = '0; e_pkt = '0; e_drop = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    run(2);
    rst = 1'b0;

    push(0, 64);
    run(5);
    push(2, 65);
    run(6);

    // Two busy ports present at reset release alternate 0,1,0,1,...
    rst = 1'b1;
    run(1);
    for (int i = 0; i < 3; i++) begin
      push(0, 64);
      push(1, 64);
    end
    run(1);
    rst = 1'b0;
    drain(100);

    // Almost-full stall in the middle of a 4-word packet.
    push(0, 200);
    run(3);
    tf_out_alf = 1'b1;
    run(5);
    tf_out_alf = 1'b0;
    drain(50);

    // Zero-length drop, then a normal packet on the same port.
    push(3, 0);
    run(3);
    push(3, 64);
    drain(50);

    // Length extremes.
    push(1, 1);
    push(2, 2047);
    drain(100);

    // Reset on the third data cycle of a 10-word packet.
    push(1, 640);
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    push(2, 64);
    push(0, 64);
    drain(50);

    // Randomised traffic with random almost-full.
    for (int i = 0; i < 3000; i++) begin
      int p, r, len;
      tf_out_alf = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(0, N - 1);
        r = $urandom_range(0, 9);
        len = (r == 0) ? 0 : (r == 1) ? 2047 : $urandom_range(1, 300);
        if (src_md_q[p].size() < 4) push(p, len);
      end
      cycle();
    end
    tf_out_alf = 1'b0;
    drain(2000);

    do_reset();
    run(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
